// File: rtl/bus_decoder_pkg.sv
// rtl/bus_decoder_pkg.sv - shared constants and types for the bus decoder
// Purpose: FSM state encodings, error cause codes, trap/error read data
//          defaults and the error record type used by bus_decoder.
package bus_decoder_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_ACCESS = 2'd1;
    localparam state_t ST_RESP   = 2'd2;

    localparam logic [1:0] CAUSE_NONE     = 2'd0;
    localparam logic [1:0] CAUSE_UNMAPPED = 2'd1;
    localparam logic [1:0] CAUSE_PRIV     = 2'd2;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'd3;

    localparam logic [31:0] ILLEGAL_INSTRUCTION = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_ERR_DATA    = 32'hdead_dead;

    typedef struct packed {
        logic        flag;
        logic [1:0]  cause;
        logic [31:0] addr;
    } err_rec_t;

endpackage

// File: rtl/bus_timeout.sv
// rtl/bus_timeout.sv - access watchdog counter for the bus decoder
// Purpose: counts ACCESS cycles without a slave ready and flags expiry.
// Ports:
//   clk, reset  clock, asynchronous active-high reset
//   start       clears the count (entry into ACCESS)
//   tick        one ACCESS cycle elapsed
//   expired     high during the TIMEOUT_CYCLES-th ticking cycle
module bus_timeout #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic tick,
    output logic expired
);

    // Expiry is seen while the last allowed cycle is still ticking, so the
    // caller leaves ACCESS after exactly TIMEOUT_CYCLES cycles.
    localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = tick && (cnt_q == LIMIT);

endmodule

// File: rtl/bus_decoder.sv
// rtl/bus_decoder.sv - address decoder / slave selector with error tracking
// Purpose: latches a CPU request, decodes it to one slave window, runs the
//          access with a timeout and returns a one-cycle response.
// Ports:
//   clk, reset                       clock, asynchronous active-high reset
//   cpu_valid/instr/addr/wdata/wstrb CPU request (wstrb 0 = read)
//   system_mode, force_trap          privilege level, trap override
//   cpu_ready, cpu_rdata             one-cycle response, registered data
//   slv_cs/we/wstrb/addr/wdata       shared slave request, one-hot select
//   slv_rdata, slv_ready             per-slave response
//   err_clear, err_flag/cause/addr   sticky error status
module bus_decoder
    import bus_decoder_pkg::*;
#(
    parameter int                         NUM_SLAVES     = 8,
    parameter logic [NUM_SLAVES*32-1:0]   SLV_BASE       = '0,
    parameter logic [NUM_SLAVES*32-1:0]   SLV_MASK       = '0,
    parameter logic [NUM_SLAVES-1:0]      SLV_PRIV       = '0,
    parameter int                         TIMEOUT_CYCLES = 255,
    parameter logic [31:0]                ERR_DATA       = DEFAULT_ERR_DATA
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cpu_valid,
    input  logic                         cpu_instr,
    input  logic [31:0]                  cpu_addr,
    input  logic [31:0]                  cpu_wdata,
    input  logic [3:0]                   cpu_wstrb,
    input  logic                         system_mode,
    input  logic                         force_trap,
    output logic                         cpu_ready,
    output logic [31:0]                  cpu_rdata,
    output logic [NUM_SLAVES-1:0]        slv_cs,
    output logic                         slv_we,
    output logic [3:0]                   slv_wstrb,
    output logic [31:0]                  slv_addr,
    output logic [31:0]                  slv_wdata,
    input  logic [NUM_SLAVES*32-1:0]     slv_rdata,
    input  logic [NUM_SLAVES-1:0]        slv_ready,
    input  logic                         err_clear,
    output logic                         err_flag,
    output logic [1:0]                   err_cause,
    output logic [31:0]                  err_addr
);

    state_t                  state_q, state_d;
    logic [NUM_SLAVES-1:0]   slv_cs_q, slv_cs_d;
    logic                    slv_we_q, slv_we_d;
    logic [3:0]              slv_wstrb_q, slv_wstrb_d;
    logic [31:0]             slv_addr_q, slv_addr_d;
    logic [31:0]             slv_wdata_q, slv_wdata_d;
    logic [31:0]             cpu_rdata_q, cpu_rdata_d;
    err_rec_t                err_q, err_d;

    logic [NUM_SLAVES-1:0]   cs_hit;
    logic                    hit_any;
    logic                    priv_block;
    logic                    sel_ready;
    logic [31:0]             sel_rdata;
    logic                    tmo_start;
    logic                    tmo_tick;
    logic                    tmo_expired;

    // Fetch vs data access does not change routing.
    logic unused_cpu_instr;
    assign unused_cpu_instr = cpu_instr;

    // Walk from the top so the lowest-index hitting window wins.
    always_comb begin
        cs_hit = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((cpu_addr & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32]) begin
                cs_hit    = '0;
                cs_hit[i] = 1'b1;
            end
        end
    end

    assign hit_any    = |cs_hit;
    assign priv_block = (|(cs_hit & SLV_PRIV)) && !system_mode;

    // The registered one-hot select masks the response of every other slave.
    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (slv_cs_q[i]) begin
                sel_rdata = sel_rdata | slv_rdata[32*i +: 32];
            end
        end
    end

    assign sel_ready = |(slv_ready & slv_cs_q);
    assign tmo_tick  = (state_q == ST_ACCESS);

    bus_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .start   (tmo_start),
        .tick    (tmo_tick),
        .expired (tmo_expired)
    );

    always_comb begin
        state_d     = state_q;
        slv_cs_d    = slv_cs_q;
        slv_we_d    = slv_we_q;
        slv_wstrb_d = slv_wstrb_q;
        slv_addr_d  = slv_addr_q;
        slv_wdata_d = slv_wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        tmo_start   = 1'b0;
        err_d       = err_q;

        // A clear is applied first so that an error recorded in the same
        // cycle overrides it below.
        if (err_clear) begin
            err_d.flag  = 1'b0;
            err_d.cause = CAUSE_NONE;
        end

        case (state_q)
            ST_IDLE: begin
                if (cpu_valid) begin
                    slv_addr_d  = cpu_addr;
                    slv_wdata_d = cpu_wdata;
                    slv_wstrb_d = cpu_wstrb;
                    slv_we_d    = |cpu_wstrb;
                    if (force_trap) begin
                        state_d     = ST_RESP;
                        cpu_rdata_d = ILLEGAL_INSTRUCTION;
                    end else if (!hit_any || priv_block) begin
                        state_d     = ST_RESP;
                        cpu_rdata_d = ERR_DATA;
                        err_d.flag  = 1'b1;
                        err_d.cause = hit_any ? CAUSE_PRIV : CAUSE_UNMAPPED;
                        err_d.addr  = cpu_addr;
                    end else begin
                        state_d   = ST_ACCESS;
                        slv_cs_d  = cs_hit;
                        tmo_start = 1'b1;
                    end
                end
            end
            ST_ACCESS: begin
                // Ready in the final allowed cycle still completes normally.
                if (sel_ready) begin
                    state_d     = ST_RESP;
                    slv_cs_d    = '0;
                    cpu_rdata_d = slv_we_q ? 32'h0 : sel_rdata;
                end else if (tmo_expired) begin
                    state_d     = ST_RESP;
                    slv_cs_d    = '0;
                    cpu_rdata_d = ERR_DATA;
                    err_d.flag  = 1'b1;
                    err_d.cause = CAUSE_TIMEOUT;
                    err_d.addr  = slv_addr_q;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d  = ST_IDLE;
                slv_cs_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            slv_cs_q    <= '0;
            slv_we_q    <= 1'b0;
            slv_wstrb_q <= '0;
            slv_addr_q  <= '0;
            slv_wdata_q <= '0;
            cpu_rdata_q <= '0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            slv_cs_q    <= slv_cs_d;
            slv_we_q    <= slv_we_d;
            slv_wstrb_q <= slv_wstrb_d;
            slv_addr_q  <= slv_addr_d;
            slv_wdata_q <= slv_wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            err_q       <= err_d;
        end
    end

    assign cpu_ready = (state_q == ST_RESP);
    assign cpu_rdata = cpu_rdata_q;
    assign slv_cs    = slv_cs_q;
    assign slv_we    = slv_we_q;
    assign slv_wstrb = slv_wstrb_q;
    assign slv_addr  = slv_addr_q;
    assign slv_wdata = slv_wdata_q;
    assign err_flag  = err_q.flag;
    assign err_cause = err_q.cause;
    assign err_addr  = err_q.addr;

endmodule

// File: tb/tb_bus_decoder.sv
// tb/tb_bus_decoder.sv - self-checking bench for bus_decoder
module tb_bus_decoder;

    localparam int NS  = 4;
    localparam int TMO = 4;

    // Slave 3 overlaps slave 2; slave 1 is privileged.
    localparam logic [NS*32-1:0] BASE = {32'hC000_0000, 32'hC100_0000, 32'h1000_0000, 32'h0000_0000};
    localparam logic [NS*32-1:0] MASK = {32'hF000_0000, 32'hFF00_0000, 32'hF000_0000, 32'hF000_0000};
    localparam logic [NS-1:0]    PRIV = 4'b0010;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              cpu_valid = 1'b0;
    logic              cpu_instr = 1'b0;
    logic [31:0]       cpu_addr = '0;
    logic [31:0]       cpu_wdata = '0;
    logic [3:0]        cpu_wstrb = '0;
    logic              system_mode = 1'b0;
    logic              force_trap = 1'b0;
    logic              cpu_ready;
    logic [31:0]       cpu_rdata;
    logic [NS-1:0]     slv_cs;
    logic              slv_we;
    logic [3:0]        slv_wstrb;
    logic [31:0]       slv_addr;
    logic [31:0]       slv_wdata;
    logic [NS*32-1:0]  slv_rdata;
    logic [NS-1:0]     slv_ready;
    logic              err_clear = 1'b0;
    logic              err_flag;
    logic [1:0]        err_cause;
    logic [31:0]       err_addr;

    bus_decoder #(
        .NUM_SLAVES     (NS),
        .SLV_BASE       (BASE),
        .SLV_MASK       (MASK),
        .SLV_PRIV       (PRIV),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cpu_valid   (cpu_valid),
        .cpu_instr   (cpu_instr),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_wstrb   (cpu_wstrb),
        .system_mode (system_mode),
        .force_trap  (force_trap),
        .cpu_ready   (cpu_ready),
        .cpu_rdata   (cpu_rdata),
        .slv_cs      (slv_cs),
        .slv_we      (slv_we),
        .slv_wstrb   (slv_wstrb),
        .slv_addr    (slv_addr),
        .slv_wdata   (slv_wdata),
        .slv_rdata   (slv_rdata),
        .slv_ready   (slv_ready),
        .err_clear   (err_clear),
        .err_flag    (err_flag),
        .err_cause   (err_cause),
        .err_addr    (err_addr)
    );

    always #5 clk = ~clk;

    // Reference windows, written from the address map above.
    logic [31:0] m_base [NS] = '{32'h0000_0000, 32'h1000_0000, 32'hC100_0000, 32'hC000_0000};
    logic [31:0] m_mask [NS] = '{32'hF000_0000, 32'hF000_0000, 32'hFF00_0000, 32'hF000_0000};
    bit          m_priv [NS] = '{1'b0, 1'b1, 1'b0, 1'b0};

    // Slave models: ready after wait_cfg[i] selected cycles; unselected
    // slaves present random ready/data noise that must be ignored.
    int          wait_cfg  [NS] = '{0, 0, 0, 0};
    logic [31:0] rdata_cfg [NS] = '{32'h0, 32'h0, 32'h0, 32'h0};
    int          cs_age = 0;
    logic [NS-1:0] noise_ready = '0;
    logic [31:0]   noise_data [NS] = '{32'h0, 32'h0, 32'h0, 32'h0};

    always @(posedge clk) begin
        if (|slv_cs) cs_age <= cs_age + 1;
        else         cs_age <= 0;
    end

    always @(negedge clk) begin
        noise_ready = 4'($urandom);
        for (int i = 0; i < NS; i++) noise_data[i] = $urandom;
    end

    always_comb begin
        slv_ready = '0;
        slv_rdata = '0;
        for (int i = 0; i < NS; i++) begin
            slv_ready[i]         = slv_cs[i] ? (cs_age >= wait_cfg[i]) : noise_ready[i];
            slv_rdata[32*i +: 32] = slv_cs[i] ? rdata_cfg[i] : noise_data[i];
        end
    end

    int checks = 0;
    int errors = 0;

    logic        m_flag = 1'b0;
    logic [1:0]  m_cause = 2'd0;
    logic [31:0] m_addr = 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_err(input string tag);
        chk({tag, "_err_flag"},  32'(err_flag),  32'(m_flag));
        chk({tag, "_err_cause"}, 32'(err_cause), 32'(m_cause));
        chk({tag, "_err_addr"},  err_addr,       m_addr);
    endtask

    // One CPU transaction; cycle 1 is the cycle cpu_valid is presented.
    // clr_cyc (0 = none) pulses err_clear during that cycle.
    task automatic run_txn(input string tag, input logic [31:0] addr, input logic [3:0] wstrb,
                           input logic [31:0] wdata, input logic mode, input logic trap,
                           input int clr_cyc);
        int          idx;
        bit          hit;
        int          e_lat, e_cs_cnt, e_err_cyc;
        logic [31:0] e_rdata;
        logic [3:0]  e_cs;
        logic [1:0]  e_cause;
        int          cyc, lat, cs_cnt;
        logic [3:0]  cs_or;
        logic [31:0] rdata_obs;

        hit = 0;
        idx = 0;
        for (int i = NS - 1; i >= 0; i--) begin
            if ((addr & m_mask[i]) == m_base[i]) begin
                hit = 1;
                idx = i;
            end
        end
        e_cs = '0;
        e_cs_cnt = 0;
        e_err_cyc = 0;
        e_cause = 2'd0;
        if (trap) begin
            e_lat = 2; e_rdata = 32'h0;
        end else if (!hit) begin
            e_lat = 2; e_rdata = 32'hdeaddead; e_err_cyc = 1; e_cause = 2'd1;
        end else if (m_priv[idx] && !mode) begin
            e_lat = 2; e_rdata = 32'hdeaddead; e_err_cyc = 1; e_cause = 2'd2;
        end else if (wait_cfg[idx] < TMO) begin
            e_lat = 3 + wait_cfg[idx];
            e_rdata = (wstrb != 0) ? 32'h0 : rdata_cfg[idx];
            e_cs[idx] = 1'b1;
            e_cs_cnt = wait_cfg[idx] + 1;
        end else begin
            e_lat = 2 + TMO; e_rdata = 32'hdeaddead;
            e_cs[idx] = 1'b1; e_cs_cnt = TMO;
            e_err_cyc = 1 + TMO; e_cause = 2'd3;
        end

        if (e_err_cyc != 0) begin
            m_flag = 1'b1; m_cause = e_cause; m_addr = addr;
            if (clr_cyc > e_err_cyc) begin m_flag = 1'b0; m_cause = 2'd0; end
        end else if (clr_cyc != 0) begin
            m_flag = 1'b0; m_cause = 2'd0;
        end

        @(negedge clk);
        cpu_valid = 1'b1; cpu_addr = addr; cpu_wstrb = wstrb; cpu_wdata = wdata;
        system_mode = mode; force_trap = trap; cpu_instr = $urandom_range(0, 1);
        err_clear = (clr_cyc == 1);
        cyc = 1; lat = 0; cs_cnt = 0; cs_or = '0; rdata_obs = 'x;
        while (lat == 0 && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            cpu_valid = 1'b0; force_trap = 1'b0;
            err_clear = (clr_cyc == cyc);
            @(negedge clk);
            if (cyc == 2) begin
                chk({tag, "_slv_addr"},  slv_addr,          addr);
                chk({tag, "_slv_wdata"}, slv_wdata,         wdata);
                chk({tag, "_slv_wstrb"}, 32'(slv_wstrb),    32'(wstrb));
                chk({tag, "_slv_we"},    32'(slv_we),       32'(wstrb != 0));
            end
            if (slv_cs != 0) begin cs_cnt++; cs_or = cs_or | slv_cs; end
            if (cpu_ready) begin lat = cyc; rdata_obs = cpu_rdata; end
        end
        err_clear = 1'b0;
        chk({tag, "_ready_cycle"}, 32'(lat),    32'(e_lat));
        chk({tag, "_rdata"},       rdata_obs,   e_rdata);
        chk({tag, "_cs_cycles"},   32'(cs_cnt), 32'(e_cs_cnt));
        chk({tag, "_cs_value"},    32'(cs_or),  32'(e_cs));
        @(negedge clk);
        chk({tag, "_ready_drop"},  32'(cpu_ready), 32'h0);
        chk_err(tag);
    endtask

    initial begin
        logic [31:0] a;
        logic [3:0]  ws;
        int          clr;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_cpu_ready", 32'(cpu_ready), 32'h0);
        chk("rst_cpu_rdata", cpu_rdata, 32'h0);
        chk("rst_slv_cs",    32'(slv_cs), 32'h0);
        chk("rst_slv_we",    32'(slv_we), 32'h0);
        chk("rst_slv_wstrb", 32'(slv_wstrb), 32'h0);
        chk("rst_slv_addr",  slv_addr, 32'h0);
        chk("rst_slv_wdata", slv_wdata, 32'h0);
        chk_err("rst");
        reset = 1'b0;

        // Overlapping windows: slave 2 beats slave 3, zero-wait read
        wait_cfg[2] = 0; rdata_cfg[2] = 32'h1234_5678;
        run_txn("slv2_read", 32'hC100_0010, 4'h0, 32'h0, 1'b0, 1'b0, 0);

        // Unmapped read
        run_txn("unmapped", 32'h8000_0000, 4'h0, 32'h0, 1'b0, 1'b0, 0);

        // Privileged slave write in user then system mode
        wait_cfg[1] = 1;
        run_txn("priv_user", 32'h1000_0040, 4'hF, 32'hA5A5_0001, 1'b0, 1'b0, 0);
        run_txn("priv_sys",  32'h1000_0040, 4'hF, 32'hA5A5_0002, 1'b1, 1'b0, 0);

        // Timeout on a slave that never answers
        wait_cfg[3] = 255;
        run_txn("timeout", 32'hC200_0000, 4'h0, 32'h0, 1'b0, 1'b0, 0);

        // Trap leaves error status alone
        run_txn("trap", 32'h0000_0100, 4'h0, 32'h0, 1'b0, 1'b1, 0);

        // Plain clear keeps the address, clears flag and cause
        @(negedge clk); err_clear = 1'b1;
        @(negedge clk); err_clear = 1'b0;
        m_flag = 1'b0; m_cause = 2'd0;
        @(negedge clk);
        chk_err("clear");

        // Clear coincident with a timeout: the new error wins
        run_txn("clr_vs_tmo", 32'hC300_0004, 4'h0, 32'h0, 1'b0, 1'b0, 1 + TMO);

        // Reset in the middle of an access
        @(negedge clk);
        cpu_valid = 1'b1; cpu_addr = 32'hC200_0000; cpu_wstrb = 4'h0; force_trap = 1'b0;
        @(posedge clk); #1 cpu_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid_cs_before", 32'(slv_cs), 32'h8);
        #2 reset = 1'b1;
        #1 chk("rst_mid_cs_async", 32'(slv_cs), 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_mid_no_ready", 32'(cpu_ready), 32'h0);
        end
        reset = 1'b0;
        m_flag = 1'b0; m_cause = 2'd0; m_addr = 32'h0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_after_no_ready", 32'(cpu_ready), 32'h0);
        end
        chk_err("rst_mid");
        wait_cfg[3] = 1; rdata_cfg[3] = 32'h0BAD_F00D;
        run_txn("after_reset", 32'hC200_0008, 4'h0, 32'h0, 1'b0, 1'b0, 0);

        // Randomised traffic against the reference model
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < NS; i++) begin
                wait_cfg[i]  = $urandom_range(0, 5);
                rdata_cfg[i] = $urandom;
            end
            case ($urandom_range(0, 5))
                0: a = {4'h0, 28'($urandom)};
                1: a = {4'h1, 28'($urandom)};
                2: a = {8'hC1, 24'($urandom)};
                3: a = {4'hC, 28'($urandom)};
                4: a = {4'h8, 28'($urandom)};
                default: a = $urandom;
            endcase
            ws  = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
            clr = ($urandom_range(0, 3) == 0) ? 1 : 0;
            run_txn("rand", a, ws, $urandom, 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 7) == 0), clr);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
